// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline register slice
package pipe_pkg;
    typedef logic [3:0] regaddr_t;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic PCSrc;
    } ctrl_t;

    // ID/EX slot: valid flag, source/dest addresses and controls
    typedef struct packed {
        logic     valid;
        regaddr_t ra1;
        regaddr_t ra2;
        regaddr_t wa3;
        ctrl_t    ctrl;
    } idex_t;

    // EX/MEM and MEM/WB slots carry only what the hazard unit watches
    typedef struct packed {
        regaddr_t wa3;
        logic     RegWrite;
        logic     PCSrc;
    } late_t;

    localparam ctrl_t    CTRL_BUBBLE = '0;
    localparam regaddr_t REG_ZERO    = 4'd0;
endpackage

// File: rtl/pipe_flop_ec.sv
// pipe_flop_ec: register with async reset, load enable and synchronous clear
module pipe_flop_ec #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;

    // clear wins over enable; with neither, the register holds
    always_comb q_d = clr ? '0 : (en ? d : q_q);

    // state register, cleared asynchronously
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= '0;
        else       q_q <= q_d;

    assign q = q_q;
endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: PC and pipeline slices driven by hazard-unit stall/flush, plus perf counters
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [WIDTH-1:0] PCNextF,
    input  logic [WIDTH-1:0] InstrF,
    input  logic [3:0]       ra1D,
    input  logic [3:0]       ra2D,
    input  logic [3:0]       wa3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic             validD,
    output logic             validE,
    output logic [3:0]       ra1E,
    output logic [3:0]       ra2E,
    output logic [3:0]       wa3E,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic             PCSrcE,
    output logic [3:0]       wa3M,
    output logic [3:0]       wa3WB,
    output logic             RegWriteM,
    output logic             RegWriteWB,
    output logic             PCSrcM,
    output logic             PCSrcWB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH:0]   ifid_d, ifid_q;
    idex_t            idex_d, idex_q;
    late_t            exmem_d, exmem_q, memwb_d, memwb_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;

    assign ifid_d = {1'b1, InstrF};

    pipe_flop_ec #(.W(WIDTH)) u_pc (
        .clk(clk), .reset(reset), .en(~StallF), .clr(1'b0), .d(PCNextF), .q(pc_q)
    );

    pipe_flop_ec #(.W(WIDTH + 1)) u_ifid (
        .clk(clk), .reset(reset), .en(~StallD), .clr(FlushD), .d(ifid_d), .q(ifid_q)
    );

    pipe_flop_ec #(.W($bits(idex_t))) u_idex (
        .clk(clk), .reset(reset), .en(1'b1), .clr(FlushE), .d(idex_d), .q(idex_q)
    );

    // a bubble in Decode enters Execute as an all-zero slot, never as live controls
    always_comb idex_d = validD ? {1'b1, ra1D, ra2D, wa3D, RegWriteD, MemtoRegD, PCSrcD}
                                : {1'b0, REG_ZERO, REG_ZERO, REG_ZERO, CTRL_BUBBLE};

    // later stages shift unconditionally; saturating counters stop at all-ones
    always_comb begin
        exmem_d      = {idex_q.wa3, idex_q.ctrl.RegWrite, idex_q.ctrl.PCSrc};
        memwb_d      = exmem_q;
        stall_cnt_d  = ((StallF | StallD) && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        bubble_cnt_d = ((FlushD | FlushE) && bubble_cnt_q != '1) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end

    // EX/MEM, MEM/WB and counter state, all discarded by reset
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            exmem_q      <= '0;
            memwb_q      <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end

    assign PCF        = pc_q;
    assign InstrD     = ifid_q[WIDTH-1:0];
    assign validD     = ifid_q[WIDTH];
    assign validE     = idex_q.valid;
    assign ra1E       = idex_q.ra1;
    assign ra2E       = idex_q.ra2;
    assign wa3E       = idex_q.wa3;
    assign RegWriteE  = idex_q.ctrl.RegWrite;
    assign MemtoRegE  = idex_q.ctrl.MemtoReg;
    assign PCSrcE     = idex_q.ctrl.PCSrc;
    assign wa3M       = exmem_q.wa3;
    assign RegWriteM  = exmem_q.RegWrite;
    assign PCSrcM     = exmem_q.PCSrc;
    assign wa3WB      = memwb_q.wa3;
    assign RegWriteWB = memwb_q.RegWrite;
    assign PCSrcWB    = memwb_q.PCSrc;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: vector table through a scoreboard plus reset and saturation sequences
module tb_pipe_stage_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
    logic [31:0] PCNextF = 32'h55, InstrF = 32'h0;
    logic [3:0]  ra1D = 4'd0, ra2D = 4'd0, wa3D = 4'd0;
    logic        RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSrcD = 1'b0;
    logic [31:0] PCF, InstrD;
    logic        validD, validE;
    logic [3:0]  ra1E, ra2E, wa3E, wa3M, wa3WB;
    logic        RegWriteE, MemtoRegE, PCSrcE, RegWriteM, RegWriteWB, PCSrcM, PCSrcWB;
    logic [3:0]  stall_cnt, bubble_cnt;

    int total = 0;
    int bad = 0;

    pipe_stage_regs #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .ra1D(ra1D), .ra2D(ra2D), .wa3D(wa3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .PCF(PCF), .InstrD(InstrD), .validD(validD), .validE(validE),
        .ra1E(ra1E), .ra2E(ra2E), .wa3E(wa3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
        .wa3M(wa3M), .wa3WB(wa3WB), .RegWriteM(RegWriteM), .RegWriteWB(RegWriteWB),
        .PCSrcM(PCSrcM), .PCSrcWB(PCSrcWB), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sf, sd, fd, fe, pcn, ins, ra1, ra2, wa3, rw, mtr, pcs;
        logic [31:0] pcf, instrd, vd, ve, ra1e, ra2e, wa3e, rwe, mte, pse;
        logic [31:0] wa3m, rwm, psm, wa3wb, rwwb, pswb, sc, bc;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic check_vec(input vec_t e, input int i);
        string t;
        t = $sformatf("v%0d.", i);
        chk({t, "PCF"}, PCF, e.pcf);
        chk({t, "InstrD"}, InstrD, e.instrd);
        chk({t, "validD"}, 32'(validD), e.vd);
        chk({t, "validE"}, 32'(validE), e.ve);
        chk({t, "ra1E"}, 32'(ra1E), e.ra1e);
        chk({t, "ra2E"}, 32'(ra2E), e.ra2e);
        chk({t, "wa3E"}, 32'(wa3E), e.wa3e);
        chk({t, "RegWriteE"}, 32'(RegWriteE), e.rwe);
        chk({t, "MemtoRegE"}, 32'(MemtoRegE), e.mte);
        chk({t, "PCSrcE"}, 32'(PCSrcE), e.pse);
        chk({t, "wa3M"}, 32'(wa3M), e.wa3m);
        chk({t, "RegWriteM"}, 32'(RegWriteM), e.rwm);
        chk({t, "PCSrcM"}, 32'(PCSrcM), e.psm);
        chk({t, "wa3WB"}, 32'(wa3WB), e.wa3wb);
        chk({t, "RegWriteWB"}, 32'(RegWriteWB), e.rwwb);
        chk({t, "PCSrcWB"}, 32'(PCSrcWB), e.pswb);
        chk({t, "stall_cnt"}, 32'(stall_cnt), e.sc);
        chk({t, "bubble_cnt"}, 32'(bubble_cnt), e.bc);
    endtask

    task automatic all_zero(input string t);
        chk({t, ".PCF"}, PCF, 0);
        chk({t, ".InstrD"}, InstrD, 0);
        chk({t, ".valid"}, 32'({validD, validE}), 0);
        chk({t, ".addrE"}, 32'({ra1E, ra2E, wa3E}), 0);
        chk({t, ".ctrlE"}, 32'({RegWriteE, MemtoRegE, PCSrcE}), 0);
        chk({t, ".M"}, 32'({wa3M, RegWriteM, PCSrcM}), 0);
        chk({t, ".WB"}, 32'({wa3WB, RegWriteWB, PCSrcWB}), 0);
        chk({t, ".cnt"}, 32'({stall_cnt, bubble_cnt}), 0);
    endtask

    initial begin
        vec_t e;
        //          sf sd fd fe pcn       ins           ra1 ra2 wa3 rw mtr pcs | pcf     instrd       vd ve r1 r2 wE rwE mtE psE wM rwM psM wWB rwWB psWB sc bc
        vecs[0]  = '{0, 0, 0, 0, 32'h04, 32'h11111111, 0, 0, 5, 1, 0, 0, 32'h04, 32'h11111111, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 32'h08, 32'h22222222, 0, 0, 5, 1, 0, 0, 32'h08, 32'h22222222, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 32'h0C, 32'h33333333, 0, 0, 6, 0, 1, 0, 32'h0C, 32'h33333333, 1, 1, 0, 0, 6, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 32'h10, 32'hE5912000, 0, 0, 7, 1, 0, 0, 32'h10, 32'hE5912000, 1, 1, 0, 0, 7, 1, 0, 0, 6, 0, 0, 5, 1, 0, 0, 0};
        vecs[4]  = '{1, 1, 0, 1, 32'h14, 32'h44444444, 1, 2, 8, 1, 1, 0, 32'h10, 32'hE5912000, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 6, 0, 0, 1, 1};
        vecs[5]  = '{0, 0, 0, 0, 32'h14, 32'h55555555, 3, 4, 9, 1, 1, 0, 32'h14, 32'h55555555, 1, 1, 3, 4, 9, 1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 1};
        vecs[6]  = '{0, 1, 1, 0, 32'h18, 32'h66666666, 0, 0, 10, 1, 0, 0, 32'h18, 32'h0, 0, 1, 0, 0, 10, 1, 0, 0, 9, 1, 0, 0, 0, 0, 2, 2};
        vecs[7]  = '{0, 0, 0, 0, 32'h1C, 32'h77777777, 0, 0, 11, 1, 0, 0, 32'h1C, 32'h77777777, 1, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 9, 1, 0, 2, 2};
        vecs[8]  = '{0, 0, 0, 0, 32'h20, 32'h88888888, 0, 0, 0, 0, 0, 1, 32'h20, 32'h88888888, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10, 1, 0, 2, 2};
        vecs[9]  = '{0, 0, 0, 0, 32'h24, 32'h99999999, 0, 0, 0, 0, 0, 0, 32'h24, 32'h99999999, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 2};
        vecs[10] = '{0, 0, 0, 0, 32'h28, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 0, 32'h28, 32'hAAAAAAAA, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2};
        vecs[11] = '{0, 0, 0, 0, 32'h2C, 32'hBBBBBBBB, 0, 0, 0, 0, 0, 0, 32'h2C, 32'hBBBBBBBB, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2};

        repeat (2) @(posedge clk);
        #1 all_zero("reset_hold");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset     = 1'b0;
            StallF    = vecs[i].sf[0];
            StallD    = vecs[i].sd[0];
            FlushD    = vecs[i].fd[0];
            FlushE    = vecs[i].fe[0];
            PCNextF   = vecs[i].pcn;
            InstrF    = vecs[i].ins;
            ra1D      = vecs[i].ra1[3:0];
            ra2D      = vecs[i].ra2[3:0];
            wa3D      = vecs[i].wa3[3:0];
            RegWriteD = vecs[i].rw[0];
            MemtoRegD = vecs[i].mtr[0];
            PCSrcD    = vecs[i].pcs[0];
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: empty at vector %0d", i);
            end else begin
                e = sb.pop_front();
                check_vec(e, i);
            end
        end

        @(negedge clk);
        PCNextF   = 32'h1234;
        RegWriteD = 1'b1;
        wa3D      = 4'd3;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 all_zero("async_reset");

        @(negedge clk);
        reset     = 1'b0;
        PCNextF   = 32'h4;
        RegWriteD = 1'b0;
        wa3D      = 4'd0;
        @(posedge clk);
        #1;
        chk("post_reset.PCF", PCF, 32'h4);
        chk("post_reset.cnt", 32'({stall_cnt, bubble_cnt}), 0);

        @(negedge clk);
        StallF  = 1'b1;
        PCNextF = 32'h100;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1 chk($sformatf("sat.stall_cnt%0d", i), 32'(stall_cnt), (i > 15) ? 15 : i);
        end
        chk("sat.bubble_cnt", 32'(bubble_cnt), 0);
        chk("sat.PCF_held", PCF, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
